// File: rtl/shared_sram_arbiter.sv
// Shares one 64x8 SRAM macro between the CPU port and a Wishbone slave.
// The CPU has priority; a starvation counter forces a Wishbone slot after MAX_WAIT denials.
module shared_sram_arbiter #(
    parameter int AW       = 6,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 8
) (
    input  logic          wb_clk_i,
    input  logic          rst_n,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [AW-1:0] wbs_adr_i,
    input  logic [DW-1:0] wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    output logic          sram_cen_n,
    output logic          sram_gwen_n,
    output logic [DW-1:0] sram_wen_n,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_ACK,
        WR_ACK
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          wb_pend;
    logic          wb_gnt;
    logic          cpu_gnt;
    logic          wb_wr_ok;
    logic          unused_sel;

    assign unused_sel = ^wbs_sel_i[3:1];

    // Grants are masked by rst_n so the macro pins idle as soon as reset asserts.
    assign wb_pend  = rst_n & wbs_cyc_i & wbs_stb_i & (state == IDLE);
    assign wb_gnt   = wb_pend & (~cpu_req | (wait_cnt == WAIT_LIM));
    assign cpu_gnt  = rst_n & cpu_req & ~wb_gnt;
    assign wb_wr_ok = ~wbs_we_i | wbs_sel_i[0];

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (wb_gnt) state_nxt = wbs_we_i ? WR_ACK : RD_WAIT;
            RD_WAIT: state_nxt = RD_ACK;
            RD_ACK:  state_nxt = IDLE;
            WR_ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sram_cen_n  = 1'b1;
        sram_gwen_n = 1'b1;
        sram_wen_n  = '1;
        sram_a      = '0;
        sram_d      = '0;
        unique case (1'b1)
            wb_gnt: begin
                sram_cen_n  = ~wb_wr_ok;
                sram_gwen_n = ~(wbs_we_i & wb_wr_ok);
                sram_wen_n  = (wbs_we_i & wb_wr_ok) ? '0 : '1;
                sram_a      = wbs_adr_i;
                sram_d      = wbs_dat_i;
            end
            cpu_gnt: begin
                sram_cen_n  = 1'b0;
                sram_gwen_n = ~cpu_we;
                sram_wen_n  = cpu_we ? '0 : '1;
                sram_a      = cpu_addr;
                sram_d      = cpu_wdata;
            end
            default: ;
        endcase
    end

    assign cpu_stall = cpu_req & wb_gnt;
    assign cpu_rdata = sram_q;
    assign wbs_ack_o = (state == WR_ACK) | (state == RD_ACK);

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (wb_pend & ~wb_gnt) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // sram_q here still reflects the WB access edge; CPU reads in RD_WAIT land later.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wbs_dat_o <= '0;
        end else if (state == RD_WAIT) begin
            wbs_dat_o <= {{(32-DW){1'b0}}, sram_q};
        end
    end

endmodule

// File: tb/tb_shared_sram_arbiter.sv
// Directed bench for shared_sram_arbiter with a behavioural SRAM macro.
// WB read results are queued at issue and checked when the ack arrives.
module tb_shared_sram_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [5:0]  wbs_adr_i = '0;
    logic [7:0]  wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [5:0]  cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_stall;
    logic        sram_cen_n;
    logic        sram_gwen_n;
    logic [7:0]  sram_wen_n;
    logic [5:0]  sram_a;
    logic [7:0]  sram_d;
    logic [7:0]  sram_q = '0;

    logic [7:0]  mem [64];
    logic [7:0]  ref_mem [64];
    logic [31:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    shared_sram_arbiter #(.AW(6), .DW(8), .MAX_WAIT(8)) dut (
        .wb_clk_i(wb_clk_i), .rst_n(rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
        .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .sram_cen_n(sram_cen_n), .sram_gwen_n(sram_gwen_n),
        .sram_wen_n(sram_wen_n), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    // Synchronous macro: q updates one edge after a read access.
    always @(posedge wb_clk_i) begin
        if (!sram_cen_n) begin
            if (!sram_gwen_n) begin
                for (int i = 0; i < 8; i++)
                    if (!sram_wen_n[i]) mem[sram_a][i] <= sram_d[i];
            end else begin
                sram_q <= mem[sram_a];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk_idle_pins(input string tag);
        chk({tag, "_cen"}, 32'(sram_cen_n), 32'h1);
        chk({tag, "_gwen"}, 32'(sram_gwen_n), 32'h1);
        chk({tag, "_wen"}, 32'(sram_wen_n), 32'hff);
        chk({tag, "_a"}, 32'(sram_a), 32'h0);
        chk({tag, "_d"}, 32'(sram_d), 32'h0);
        chk({tag, "_ack"}, 32'(wbs_ack_o), 32'h0);
        chk({tag, "_dat"}, wbs_dat_o, 32'h0);
        chk({tag, "_stall"}, 32'(cpu_stall), 32'h0);
    endtask

    // Issues one WB access, measures cycles to ack, checks read data.
    task automatic wb_txn(input string tag, input logic we,
                          input logic [5:0] adr, input logic [7:0] dat,
                          input logic [3:0] sel, input int lat,
                          output logic cen0);
        int k;
        logic [31:0] e;
        if (!we) exp_q.push_back({24'h0, ref_mem[adr]});
        else if (sel[0]) ref_mem[adr] = dat;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        #2;
        cen0 = sram_cen_n;
        k = 0;
        while (wbs_ack_o !== 1'b1 && k < 20) begin
            nxt();
            #2;
            k++;
        end
        chk({tag, "_lat"}, 32'(k), 32'(lat));
        if (!we) begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, wbs_dat_o, e);
        end
        nxt();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
    endtask

    initial begin
        logic c0;
        int denied;
        logic [31:0] e;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end

        #2;
        chk_idle_pins("reset");
        nxt();
        rst_n = 1'b1;
        nxt();

        // Plain WB write, pins checked in the grant cycle, then readback.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 6'd5; wbs_dat_i = 8'hA5; wbs_sel_i = 4'h1;
        ref_mem[5] = 8'hA5;
        #2;
        chk("w1_a", 32'(sram_a), 32'd5);
        chk("w1_d", 32'(sram_d), 32'hA5);
        chk("w1_gwen", 32'(sram_gwen_n), 32'h0);
        chk("w1_cen", 32'(sram_cen_n), 32'h0);
        chk("w1_wen", 32'(sram_wen_n), 32'h00);
        chk("w1_ack_n", 32'(wbs_ack_o), 32'h0);
        nxt();
        #2;
        chk("w1_ack", 32'(wbs_ack_o), 32'h1);
        nxt();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        #2;
        chk("w1_ack_pulse", 32'(wbs_ack_o), 32'h0);
        nxt();
        wb_txn("r1", 1'b0, 6'd5, 8'h00, 4'h1, 2, c0);

        // Write with sel[0]=0 must not touch the macro.
        wb_txn("w7", 1'b1, 6'd7, 8'h11, 4'h1, 1, c0);
        wb_txn("w7n", 1'b1, 6'd7, 8'h3C, 4'h0, 1, c0);
        chk("w7n_cen", 32'(c0), 32'h1);
        wb_txn("r7", 1'b0, 6'd7, 8'h00, 4'h1, 2, c0);

        // Starvation: CPU hammers address 0 while WB reads address 5.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd0;
        exp_q.push_back({24'h0, ref_mem[5]});
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 6'd5; wbs_sel_i = 4'h1;
        denied = 0;
        #2;
        while (cpu_stall !== 1'b1 && denied < 20) begin
            denied++;
            nxt();
            #2;
        end
        chk("starve_cnt", 32'(denied), 32'd8);
        chk("starve_a", 32'(sram_a), 32'd5);
        chk("starve_gwen", 32'(sram_gwen_n), 32'h1);
        nxt();
        #2;
        chk("stall_once", 32'(cpu_stall), 32'h0);
        chk("starve_cpu_a", 32'(sram_a), 32'd0);
        chk("starve_ack_n", 32'(wbs_ack_o), 32'h0);
        nxt();
        #2;
        chk("starve_ack", 32'(wbs_ack_o), 32'h1);
        e = exp_q.pop_front();
        chk("starve_rdata", wbs_dat_o, e);
        nxt();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; cpu_req = 1'b0;
        nxt();

        // CPU and WB arrive together: CPU wins without a stall.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd20; cpu_wdata = 8'h77;
        ref_mem[20] = 8'h77;
        exp_q.push_back({24'h0, ref_mem[7]});
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 6'd7; wbs_sel_i = 4'h1;
        #2;
        chk("tie_stall", 32'(cpu_stall), 32'h0);
        chk("tie_a", 32'(sram_a), 32'd20);
        chk("tie_gwen", 32'(sram_gwen_n), 32'h0);
        nxt();
        cpu_req = 1'b0;
        #2;
        chk("tie_wait", 32'(dut.wait_cnt), 32'd1);
        chk("tie_wb_a", 32'(sram_a), 32'd7);
        nxt();
        nxt();
        #2;
        chk("tie_ack", 32'(wbs_ack_o), 32'h1);
        e = exp_q.pop_front();
        chk("tie_rdata", wbs_dat_o, e);
        nxt();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        nxt();

        // Reset during RD_WAIT drops the ack and clears the outputs.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 6'd5; wbs_sel_i = 4'h1;
        nxt();
        rst_n = 1'b0;
        #2;
        chk_idle_pins("mid_rst");
        for (int i = 0; i < 3; i++) begin
            nxt();
            #2;
            chk("mid_rst_ack", 32'(wbs_ack_o), 32'h0);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        nxt();
        rst_n = 1'b1;
        nxt();
        wb_txn("post_rst", 1'b0, 6'd20, 8'h00, 4'h1, 2, c0);

        // CPU write then read of the same word, back to back.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd63; cpu_wdata = 8'h5A;
        #2;
        chk("cw_cen", 32'(sram_cen_n), 32'h0);
        chk("cw_gwen", 32'(sram_gwen_n), 32'h0);
        chk("cw_a", 32'(sram_a), 32'd63);
        chk("cw_d", 32'(sram_d), 32'h5A);
        nxt();
        cpu_we = 1'b0;
        #2;
        chk("cr_gwen", 32'(sram_gwen_n), 32'h1);
        nxt();
        cpu_req = 1'b0;
        #2;
        chk("cr_rdata", 32'(cpu_rdata), 32'h5A);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
